// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, butterfly mode encoding and
// the round-half-up constant used after fixed-point multiplies.
package fft_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 21;
  localparam int unsigned DEF_FRAC_BITS  = 15;
  localparam int unsigned DEF_TW_WIDTH   = 16;

  typedef enum logic {
    MODE_DIT = 1'b0,
    MODE_DIF = 1'b1
  } mode_e;

  // Half an LSB of the result once a Q1.(tw_width-1) product is shifted down.
  function automatic longint round_const(input int unsigned tw_width);
    return longint'(1) <<< (tw_width - 2);
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Combinational complex multiply x*w with a Q1.(TW_WIDTH-1) twiddle, rounded
// half-up back to the data scale.
module cmul_round
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN = 22,
  parameter int unsigned TW_WIDTH      = 16
) (
  input  logic signed [DATA_WIDTH_IN-1:0] x_re,
  input  logic signed [DATA_WIDTH_IN-1:0] x_im,
  input  logic signed [TW_WIDTH-1:0]      w_re,
  input  logic signed [TW_WIDTH-1:0]      w_im,
  output logic signed [DATA_WIDTH_IN+1:0] y_re,
  output logic signed [DATA_WIDTH_IN+1:0] y_im
);

  localparam int unsigned PW = DATA_WIDTH_IN + TW_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(round_const(TW_WIDTH));

  logic signed [PW-1:0] xr, xi, wr, wi, sum_re, sum_im;

  always_comb begin
    xr     = PW'(x_re);
    xi     = PW'(x_im);
    wr     = PW'(w_re);
    wi     = PW'(w_im);
    sum_re = xr * wr - xi * wi + RND;
    sum_im = xi * wr + xr * wi + RND;
  end

  assign y_re = (DATA_WIDTH_IN + 2)'(sum_re >>> (TW_WIDTH - 1));
  assign y_im = (DATA_WIDTH_IN + 2)'(sum_im >>> (TW_WIDTH - 1));

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 butterfly (DIT/DIF per transaction) with
// optional halving, saturation, sticky overflow and valid/ready flow control.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
  parameter int unsigned TW_WIDTH   = DEF_TW_WIDTH,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  mode_i,
  input  logic                  scale_i,
  input  logic [TW_WIDTH-1:0]   twid_re_i,
  input  logic [TW_WIDTH-1:0]   twid_im_i,
  input  logic [DATA_WIDTH-1:0] a_re_i,
  input  logic [DATA_WIDTH-1:0] a_im_i,
  input  logic [DATA_WIDTH-1:0] b_re_i,
  input  logic [DATA_WIDTH-1:0] b_im_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] a_re_o,
  output logic [DATA_WIDTH-1:0] a_im_o,
  output logic [DATA_WIDTH-1:0] b_re_o,
  output logic [DATA_WIDTH-1:0] b_im_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  if (LATENCY != 3) begin : g_latency_check
    $error("butterfly_pipe: LATENCY must be 3");
  end
  if (FRAC_BITS >= DATA_WIDTH) begin : g_frac_check
    $error("butterfly_pipe: FRAC_BITS must be below DATA_WIDTH");
  end

  localparam int unsigned XW = DATA_WIDTH + 1;  // multiplier operand / A path
  localparam int unsigned RW = DATA_WIDTH + 3;  // rounded product
  localparam int unsigned SW = DATA_WIDTH + 4;  // final sum before clamp
  localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(longint'(1) <<< (DATA_WIDTH - 1)));

  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] x);
    return (x + SW'(1)) >>> 1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] x,
                                                output logic clamped);
    logic [DATA_WIDTH-1:0] r;
    clamped = 1'b1;
    if (x > SAT_MAX)      r = DATA_WIDTH'(SAT_MAX);
    else if (x < SAT_MIN) r = DATA_WIDTH'(SAT_MIN);
    else begin
      r       = DATA_WIDTH'(x);
      clamped = 1'b0;
    end
    return r;
  endfunction

  logic adv;
  assign adv        = ~(out_valid_o & ~out_ready_i);
  assign in_ready_o = adv;

  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_WIDTH-1:0]   w_re, w_im;
  assign a_re = a_re_i;
  assign a_im = a_im_i;
  assign b_re = b_re_i;
  assign b_im = b_im_i;
  assign w_re = twid_re_i;
  assign w_im = twid_im_i;

  // The single multiplier sees B (DIT) or A-B (DIF); the other path carries A or A+B.
  logic signed [XW-1:0] x_re_d, x_im_d, p_re_d, p_im_d;
  always_comb begin
    if (mode_i == MODE_DIT) begin
      x_re_d = XW'(b_re);
      x_im_d = XW'(b_im);
      p_re_d = XW'(a_re);
      p_im_d = XW'(a_im);
    end else begin
      x_re_d = XW'(a_re) - XW'(b_re);
      x_im_d = XW'(a_im) - XW'(b_im);
      p_re_d = XW'(a_re) + XW'(b_re);
      p_im_d = XW'(a_im) + XW'(b_im);
    end
  end

  logic                 s1_valid, s1_scale;
  mode_e                s1_mode;
  logic signed [XW-1:0] s1_x_re, s1_x_im, s1_p_re, s1_p_im;
  logic signed [TW_WIDTH-1:0] s1_w_re, s1_w_im;

  logic signed [RW-1:0] r_re, r_im;

  cmul_round #(
    .DATA_WIDTH_IN (XW),
    .TW_WIDTH      (TW_WIDTH)
  ) u_cmul (
    .x_re (s1_x_re),
    .x_im (s1_x_im),
    .w_re (s1_w_re),
    .w_im (s1_w_im),
    .y_re (r_re),
    .y_im (r_im)
  );

  logic                 s2_valid, s2_scale;
  mode_e                s2_mode;
  logic signed [XW-1:0] s2_p_re, s2_p_im;
  logic signed [RW-1:0] s2_r_re, s2_r_im;

  logic signed [SW-1:0]  f_a_re, f_a_im, f_b_re, f_b_im;
  logic [DATA_WIDTH-1:0] n_a_re, n_a_im, n_b_re, n_b_im;
  logic [3:0]            clp;
  logic                  clamp_any;

  always_comb begin
    clp = '0;
    if (s2_mode == MODE_DIT) begin
      f_a_re = SW'(s2_p_re) + SW'(s2_r_re);
      f_a_im = SW'(s2_p_im) + SW'(s2_r_im);
      f_b_re = SW'(s2_p_re) - SW'(s2_r_re);
      f_b_im = SW'(s2_p_im) - SW'(s2_r_im);
    end else begin
      f_a_re = SW'(s2_p_re);
      f_a_im = SW'(s2_p_im);
      f_b_re = SW'(s2_r_re);
      f_b_im = SW'(s2_r_im);
    end
    if (s2_scale) begin
      f_a_re = half(f_a_re);
      f_a_im = half(f_a_im);
      f_b_re = half(f_b_re);
      f_b_im = half(f_b_im);
    end
    n_a_re    = sat(f_a_re, clp[0]);
    n_a_im    = sat(f_a_im, clp[1]);
    n_b_re    = sat(f_b_re, clp[2]);
    n_b_im    = sat(f_b_im, clp[3]);
    clamp_any = |clp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_mode     <= MODE_DIT;
      s1_scale    <= 1'b0;
      s1_x_re     <= '0;
      s1_x_im     <= '0;
      s1_p_re     <= '0;
      s1_p_im     <= '0;
      s1_w_re     <= '0;
      s1_w_im     <= '0;
      s2_valid    <= 1'b0;
      s2_mode     <= MODE_DIT;
      s2_scale    <= 1'b0;
      s2_p_re     <= '0;
      s2_p_im     <= '0;
      s2_r_re     <= '0;
      s2_r_im     <= '0;
      out_valid_o <= 1'b0;
      a_re_o      <= '0;
      a_im_o      <= '0;
      b_re_o      <= '0;
      b_im_o      <= '0;
      ovf_o       <= 1'b0;
    end else begin
      if (adv) begin
        s1_valid    <= in_valid_i;
        s1_mode     <= mode_e'(mode_i);
        s1_scale    <= scale_i;
        s1_x_re     <= x_re_d;
        s1_x_im     <= x_im_d;
        s1_p_re     <= p_re_d;
        s1_p_im     <= p_im_d;
        s1_w_re     <= w_re;
        s1_w_im     <= w_im;
        s2_valid    <= s1_valid;
        s2_mode     <= s1_mode;
        s2_scale    <= s1_scale;
        s2_p_re     <= s1_p_re;
        s2_p_im     <= s1_p_im;
        s2_r_re     <= r_re;
        s2_r_im     <= r_im;
        out_valid_o <= s2_valid;
        a_re_o      <= n_a_re;
        a_im_o      <= n_a_im;
        b_re_o      <= n_b_re;
        b_im_o      <= n_b_im;
      end
      // A clamp landing on the output in the same cycle as a clear keeps the flag set.
      ovf_o <= (adv & s2_valid & clamp_any) | (ovf_o & ~ovf_clr_i);
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors plus random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_butterfly_pipe;

  localparam int DW = 21;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic          scale = 1'b0;
  logic [TW-1:0] twid_re = '0, twid_im = '0;
  logic [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  always #5 clk = ~clk;

  butterfly_pipe #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (15),
    .TW_WIDTH   (TW),
    .LATENCY    (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_i      (mode),
    .scale_i     (scale),
    .twid_re_i   (twid_re),
    .twid_im_i   (twid_im),
    .a_re_i      (a_re),
    .a_im_i      (a_im),
    .b_re_i      (b_re),
    .b_im_i      (b_im),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .a_re_o      (a_re_q),
    .a_im_o      (a_im_q),
    .b_re_o      (b_re_q),
    .b_im_o      (b_im_q),
    .ovf_o       (ovf),
    .ovf_clr_i   (ovf_clr)
  );

  typedef struct {
    longint ar, ai, br, bi;
  } res_t;

  res_t   q[$];
  int     errors = 0;
  int     checks = 0;
  int     received = 0;
  bit     cur_m, cur_s;
  longint cur_v[6];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint x);
    return (x + (longint'(1) <<< (TW - 2))) >>> (TW - 1);
  endfunction

  // Butterfly result from the arithmetic definition: exact products, round, scale, clamp.
  function automatic res_t model(input bit m, input bit s, input longint v[6]);
    longint ar, ai, br, bi, wr, wi, rr, ri, o[4];
    longint hi, lo;
    res_t   r;
    ar = v[0]; ai = v[1]; br = v[2]; bi = v[3]; wr = v[4]; wi = v[5];
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (!m) begin
      rr = rnd(br * wr - bi * wi);
      ri = rnd(bi * wr + br * wi);
      o  = '{ar + rr, ai + ri, ar - rr, ai - ri};
    end else begin
      rr = ar - br;
      ri = ai - bi;
      o  = '{ar + br, ai + bi, rnd(rr * wr - ri * wi), rnd(ri * wr + rr * wi)};
    end
    for (int i = 0; i < 4; i++) begin
      if (s) o[i] = (o[i] + 1) >>> 1;
      if (o[i] > hi) o[i] = hi;
      if (o[i] < lo) o[i] = lo;
    end
    r.ar = o[0]; r.ai = o[1]; r.br = o[2]; r.bi = o[3];
    return r;
  endfunction

  task automatic drive(input bit m, input bit s, input longint ar, input longint ai,
                       input longint br, input longint bi, input longint wr, input longint wi);
    mode    = m;
    scale   = s;
    a_re    = DW'(ar);
    a_im    = DW'(ai);
    b_re    = DW'(br);
    b_im    = DW'(bi);
    twid_re = TW'(wr);
    twid_im = TW'(wi);
    cur_m   = m;
    cur_s   = s;
    cur_v   = '{ar, ai, br, bi, wr, wi};
  endtask

  function automatic longint rdata();
    logic [DW-1:0] raw;
    raw = DW'($urandom);
    if ($urandom_range(1, 0) == 1) return longint'($signed(raw));
    return longint'($urandom_range(65535, 0)) - 32768;
  endfunction

  function automatic longint rtw();
    logic [TW-1:0] raw;
    raw = TW'($urandom);
    return longint'($signed(raw));
  endfunction

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), rdata(), rdata(), rdata(), rdata(), rtw(), rtw());
  endtask

  // One clock: score the output handshake and record the input handshake.
  task automatic tick(output bit accepted);
    res_t e;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("sb_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_a_re", $signed(a_re_q), e.ar);
        chk("sb_a_im", $signed(a_im_q), e.ai);
        chk("sb_b_re", $signed(b_re_q), e.br);
        chk("sb_b_im", $signed(b_im_q), e.bi);
        received++;
      end
    end
    if (accepted) q.push_back(model(cur_m, cur_s, cur_v));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input bit m, input bit s,
                          input longint ar, input longint ai, input longint br, input longint bi,
                          input longint wr, input longint wi,
                          input longint ear, input longint eai, input longint ebr, input longint ebi,
                          input bit eovf);
    bit acc;
    drive(m, s, ar, ai, br, bi, wr, wi);
    in_valid = 1'b1;
    tick(acc);
    chk({tag, "_accept"}, acc, 1);
    in_valid = 1'b0;
    tick(acc);
    chk({tag, "_not_early"}, out_valid, 0);
    tick(acc);
    chk({tag, "_valid_at_3"}, out_valid, 1);
    chk({tag, "_a_re"}, $signed(a_re_q), ear);
    chk({tag, "_a_im"}, $signed(a_im_q), eai);
    chk({tag, "_b_re"}, $signed(b_re_q), ebr);
    chk({tag, "_b_im"}, $signed(b_im_q), ebi);
    chk({tag, "_ovf"}, ovf, eovf);
    tick(acc);
    chk({tag, "_consumed"}, out_valid, 0);
  endtask

  initial begin
    bit            acc, pending, stalled;
    int            n_sent, rec0;
    logic [DW-1:0] snap[4];

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_a_re", a_re_q, 0);
    chk("rst_b_im", b_im_q, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_one("dit1", 0, 0, 16384, 0, 16384, 0, 30274, -12540, 31521, -6270, 1247, 6270, 0);
    send_one("dit2", 0, 0, 32768, 0, 0, -16384, 30274, -12540, 26498, -15137, 39038, 15137, 0);
    send_one("dif3", 1, 0, 16384, 0, 0, 16384, 30274, -12540, 16384, 16384, 8867, -21407, 0);
    send_one("sat4", 0, 0, 1048575, 0, 1048575, 0, 32767, 0, 1048575, 0, 32, 0, 1);
    send_one("sat4s", 0, 1, 1048575, 0, 1048575, 0, 32767, 0, 1048559, 0, 16, 0, 1);
    ovf_clr = 1'b1;
    tick(acc);
    ovf_clr = 1'b0;
    chk("ovf_clear", ovf, 0);

    // Clear held through a clamping transaction: set must win, then clear afterwards.
    ovf_clr = 1'b1;
    send_one("setwins", 0, 0, 1048575, 0, 1048575, 0, 32767, 0, 1048575, 0, 32, 0, 1);
    chk("ovf_cleared_after", ovf, 0);
    ovf_clr = 1'b0;

    send_one("negsat", 0, 0, -1048576, 0, -1048576, 0, -32768, 0, 0, 0, -1048576, 0, 1);
    ovf_clr = 1'b1;
    tick(acc);
    ovf_clr = 1'b0;
    chk("ovf_clear2", ovf, 0);

    // Back-to-back stream of 6 with a 5-cycle downstream stall
    rec0    = received;
    n_sent  = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 60 && (n_sent < 6 || q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      if (!pending && n_sent < 6) begin
        drive_random();
        pending = 1'b1;
      end
      in_valid = pending;
      snap     = '{a_re_q, a_im_q, b_re_q, b_im_q};
      stalled  = out_valid && !out_ready;
      #1;
      chk("stream_in_ready", in_ready, !stalled);
      tick(acc);
      if (acc) begin
        n_sent++;
        pending = 1'b0;
      end
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_a_re", a_re_q, snap[0]);
        chk("hold_a_im", a_im_q, snap[1]);
        chk("hold_b_re", b_re_q, snap[2]);
        chk("hold_b_im", b_im_q, snap[3]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", received - rec0, 6);
    chk("stream_drained", q.size(), 0);

    // Random traffic with random backpressure
    rec0   = received;
    n_sent = 0;
    pending = 1'b0;
    for (int cyc = 0; cyc < 600 && (n_sent < 40 || q.size() > 0); cyc++) begin
      out_ready = ($urandom_range(9, 0) < 7);
      if (!pending && n_sent < 40 && $urandom_range(3, 0) != 0) begin
        drive_random();
        pending = 1'b1;
      end
      in_valid = pending;
      tick(acc);
      if (acc) begin
        n_sent++;
        pending = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("random_count", received - rec0, 40);
    chk("random_drained", q.size(), 0);

    // Reset with transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      in_valid = 1'b1;
      tick(acc);
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_a_re", a_re_q, 0);
    chk("midrst_ovf", ovf, 0);
    q.delete();
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      chk("post_rst_no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 butterfly for the streaming FFT datapath; next generation of the combinational butterfly.
- Adds valid/ready flow control and a fixed 3-cycle latency.
- Adds per-transaction DIT/DIF mode select and optional divide-by-2 scaling.
- Adds round-half-up and saturation with a sticky overflow flag.
- Sits between the twiddle ROM/CORDIC twiddle generator and the stage reorder buffers.

Parameters:
DATA_WIDTH, 21, signed sample width per real/imag component (Q format, FRAC_BITS fractional)
FRAC_BITS, 15, fractional bits of data samples
TW_WIDTH, 16, signed twiddle width per component, Q1.(TW_WIDTH-1)
LATENCY, 3, fixed input-to-output latency in cycles; only value 3 is legal (elaboration error otherwise)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input transaction valid
in_ready_o  out  1  block can accept input this cycle
mode_i  in  1  0 = DIT, 1 = DIF; sampled with the transaction
scale_i  in  1  1 = halve both outputs (rounded); sampled with the transaction
twid_re_i  in  TW_WIDTH  twiddle real part
twid_im_i  in  TW_WIDTH  twiddle imaginary part
a_re_i, a_im_i, b_re_i, b_im_i  in  DATA_WIDTH  operands A and B
out_valid_o  out  1  output transaction valid
out_ready_i  in  1  downstream accepts output
a_re_o, a_im_o, b_re_o, b_im_o  out  DATA_WIDTH  results A' and B'
ovf_o  out  1  sticky saturation flag
ovf_clr_i  in  1  synchronous clear of ovf_o

Behaviour:
- Reset: one clock, asynchronous active-low reset, clk_i / rst_ni. Reset clears all stage valids, out_valid_o=0, ovf_o=0, and all data outputs to 0. in_ready_o=1 after reset. Reset mid-operation discards every in-flight transaction.
- Handshake:
  - stall = out_valid_o & ~out_ready_i; in_ready_o = ~stall. Combinational, no dependency on in_valid_i.
  - When stall=0, every stage advances each cycle. Bubbles propagate as valid=0.
  - When stall=1, all stage registers and outputs hold.
  - A transfer occurs on in_valid_i & in_ready_o. Its result appears with out_valid_o=1 exactly 3 cycles later when no stall occurs; each stall cycle adds one cycle.
  - No transaction is lost or duplicated. Outputs are stable while out_valid_o & ~out_ready_i.
- DIT (mode_i=0): A' = A + W·B, B' = A - W·B.
  - S1 registers the four products Br·Wr, Bi·Wi, Bi·Wr, Br·Wi, each at full width DATA_WIDTH+TW_WIDTH, plus A.
  - S2 forms re = BrWr - BiWi and im = BiWr + BrWi at width DATA_WIDTH+TW_WIDTH+1. It adds 2^(TW_WIDTH-2), then arithmetic-shifts right by TW_WIDTH-1 (round-half-up, once per component).
  - S3 forms A ± rotated B at width DATA_WIDTH+2.
- DIF (mode_i=1): A' = A + B, B' = (A - B)·W.
  - S1 registers A+B and A-B at width DATA_WIDTH+1.
  - S2 performs the complex multiply of (A-B) with W, rounded the same way as DIT.
  - S3 passes the results through to scale/saturate.
- Scale: when scale_i=1, S3 adds 1 then arithmetic-shifts right by 1 on each full-width result before saturation. Scaling applies to A' and B' in both modes.
- Saturation:
  - Each output component is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Any clamp on a transaction that reaches out_valid_o sets ovf_o.
  - ovf_o stays set until ovf_clr_i. If a clamp and ovf_clr_i occur in the same cycle, set wins.
- mode_i and scale_i travel with their transaction; changing them back-to-back between transactions is legal.

Decomposition:
- Shared package fft_pkg:
  - default DATA_WIDTH, FRAC_BITS, TW_WIDTH
  - MODE_DIT / MODE_DIF constants
  - rounding-constant function
- One sub-module: cmul_round. It is a combinational complex multiply with round-half-up and parameters DATA_WIDTH_IN, TW_WIDTH. It is instantiated once, and its input is muxed between B (DIT) and A-B (DIF).
- Saturation is a local function.

Test Plan:
1. DIT, W=(30274,-12540), A=(16384,0), B=(16384,0), scale=0 -> after 3 cycles A'=(31521,-6270), B'=(1247,6270), ovf_o=0.
2. DIT, same W, A=(32768,0), B=(0,-16384) -> A'=(26498,-15137), B'=(39038,15137).
3. DIF, same W, A=(16384,0), B=(0,16384) -> A'=(16384,16384), B'=(8867,-21407).
4. DIT, W=(32767,0), A=B=(1048575,0):
   - scale=0 -> A'=(1048575,0) saturated, B'=(32,0), ovf_o=1.
   - Repeat with scale=1 -> A'=(1048559,0), B'=(16,0).
   - ovf_clr_i pulse -> ovf_o=0.
5. Stream 6 back-to-back transactions and hold out_ready_i=0 for 5 cycles mid-stream -> in_ready_o=0 during the stall, outputs held, all 6 results in order with none lost or duplicated.
6. Assert rst_ni=0 with 2 transactions in flight -> out_valid_o=0 immediately, with no stale output after release.
